// File: rtl/uart_interrupt_arbiter_pkg.sv
// Shared types and helpers for the UART interrupt arbiter.
// Covers source IDs, arbiter FSM states and pending-vector helpers.
package UART_pkg;

    localparam int INT_SRC_NUM = 7;

    typedef enum logic [2:0] {
        INT_NONE       = 3'd0,
        INT_CFG_ERR    = 3'd1,
        INT_OVERRUN    = 3'd2,
        INT_FRAME      = 3'd3,
        INT_PARITY     = 3'd4,
        INT_RX_TIMEOUT = 3'd5,
        INT_CFG_DONE   = 3'd6,
        INT_TX_DONE    = 3'd7
    } uart_int_id_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } int_arb_state_e;

    // Lowest set bit wins: bit 0 (ID 1) has the highest priority.
    function automatic uart_int_id_e lowest_pending(input logic [INT_SRC_NUM-1:0] vec);
        uart_int_id_e id;
        id = INT_NONE;
        for (int k = INT_SRC_NUM - 1; k >= 0; k--) begin
            if (vec[k]) begin
                id = uart_int_id_e'(3'(k + 1));
            end
        end
        return id;
    endfunction

    function automatic logic [INT_SRC_NUM-1:0] id_to_mask(input uart_int_id_e id);
        logic [INT_SRC_NUM-1:0] m;
        m = '0;
        for (int k = 0; k < INT_SRC_NUM; k++) begin
            m[k] = (id == uart_int_id_e'(3'(k + 1)));
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_interrupt_arbiter_if.sv
// Event, acknowledge and status signals between the UART controller/host and the arbiter.
interface uart_int_if;
    import UART_pkg::*;

    logic [INT_SRC_NUM-1:0] int_enable_i;
    logic                   configuration_error_i;
    logic                   overrun_error_i;
    logic                   frame_error_i;
    logic                   parity_error_i;
    logic                   configuration_done_i;
    logic                   tx_done_i;
    logic                   rx_fifo_empty_i;
    logic                   rx_fifo_read_i;
    logic                   interrupt_ackn_i;
    logic                   int_o;
    uart_int_id_e           int_id_o;
    logic [INT_SRC_NUM-1:0] pending_o;

    modport master (
        output int_enable_i, configuration_error_i, overrun_error_i, frame_error_i,
               parity_error_i, configuration_done_i, tx_done_i, rx_fifo_empty_i,
               rx_fifo_read_i, interrupt_ackn_i,
        input  int_o, int_id_o, pending_o
    );

    modport slave (
        input  int_enable_i, configuration_error_i, overrun_error_i, frame_error_i,
               parity_error_i, configuration_done_i, tx_done_i, rx_fifo_empty_i,
               rx_fifo_read_i, interrupt_ackn_i,
        output int_o, int_id_o, pending_o
    );

endinterface

// File: rtl/uart_interrupt_arbiter_rx_timeout.sv
// RX timeout: counts idle cycles of a non-empty RX FIFO and emits one pulse per stall.
module uart_rx_timeout #(
    parameter int RX_TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rx_fifo_empty_i,
    input  logic rx_fifo_read_i,
    output logic timeout_o
);

    localparam int              CNT_W    = $clog2(RX_TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             timeout_q, timeout_d;

    // Next-state: clear on read/empty, count otherwise, pulse once when the count hits the last value.
    always_comb begin
        cnt_d     = cnt_q;
        fired_d   = fired_q;
        timeout_d = 1'b0;
        if (rx_fifo_empty_i || rx_fifo_read_i) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q == (CNT_LAST - CNT_W'(1))) && !fired_q) begin
                timeout_d = 1'b1;
                fired_d   = 1'b1;
            end else begin
                timeout_d = 1'b0;
            end
        end else begin
            cnt_d = CNT_LAST;
        end
    end

    // Counter, fired flag and pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            fired_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            fired_q   <= fired_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/uart_interrupt_arbiter.sv
// Latches UART interrupt events and presents them one at a time, highest priority first,
// holding each until the host acknowledges it.
module uart_interrupt_arbiter
    import UART_pkg::*;
#(
    parameter int RX_TIMEOUT_CYC = 1024
) (
    input logic      clk_i,
    input logic      rst_n_i,
    uart_int_if.slave bus
);

    logic                   timeout_s;
    logic [INT_SRC_NUM-1:0] set_s;
    logic [INT_SRC_NUM-1:0] presented_s;
    logic [INT_SRC_NUM-1:0] clr_s;
    logic [INT_SRC_NUM-1:0] active_s;
    logic                   ack_s;

    logic [INT_SRC_NUM-1:0] pending_q, pending_d;
    int_arb_state_e         state_q, state_d;
    logic                   int_q, int_d;
    uart_int_id_e           id_q, id_d;

    uart_rx_timeout #(
        .RX_TIMEOUT_CYC (RX_TIMEOUT_CYC)
    ) u_rx_timeout (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .rx_fifo_empty_i (bus.rx_fifo_empty_i),
        .rx_fifo_read_i  (bus.rx_fifo_read_i),
        .timeout_o       (timeout_s)
    );

    // Pending vector update: the presented source survives an enable drop, and a new set beats the ack clear.
    always_comb begin
        set_s = {bus.tx_done_i, bus.configuration_done_i, timeout_s, bus.parity_error_i,
                 bus.frame_error_i, bus.overrun_error_i, bus.configuration_error_i}
                & bus.int_enable_i;
        presented_s = (state_q == ASSERT) ? id_to_mask(id_q) : '0;
        ack_s       = (state_q == ASSERT) && bus.interrupt_ackn_i;
        clr_s       = ack_s ? presented_s : '0;
        active_s    = pending_q & bus.int_enable_i;
        pending_d   = ((pending_q & (bus.int_enable_i | presented_s)) & ~clr_s) | set_s;
    end

    // Presentation FSM next-state and output logic.
    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (active_s != '0) begin
                    id_d    = lowest_pending(active_s);
                    int_d   = 1'b1;
                    state_d = ASSERT;
                end else begin
                    id_d  = INT_NONE;
                    int_d = 1'b0;
                end
            end
            ASSERT: begin
                if (ack_s) begin
                    id_d    = INT_NONE;
                    int_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    int_d = 1'b1;
                end
            end
            GAP: begin
                id_d    = INT_NONE;
                int_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                id_d    = INT_NONE;
                int_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pending and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            int_q     <= 1'b0;
            id_q      <= INT_NONE;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            int_q     <= int_d;
            id_q      <= id_d;
        end
    end

    assign bus.int_o     = int_q;
    assign bus.int_id_o  = id_q;
    assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_uart_interrupt_arbiter.sv
// Directed bench for uart_interrupt_arbiter with hand-computed expected values.
module tb_uart_interrupt_arbiter;
    import UART_pkg::*;

    logic clk;
    logic rst_n;
    int   checks_n;
    int   fail_n;
    int   k;
    logic seen;

    uart_int_if bus_if ();

    uart_interrupt_arbiter #(
        .RX_TIMEOUT_CYC (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        bus_if.interrupt_ackn_i = 1'b1;
        tick();
        bus_if.interrupt_ackn_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic i, input logic [2:0] id, input logic [6:0] p);
        check({tag, "_int"}, 32'(bus_if.int_o), 32'(i));
        check({tag, "_id"}, 32'(bus_if.int_id_o), 32'(id));
        check({tag, "_pend"}, 32'(bus_if.pending_o), 32'(p));
    endtask

    initial begin
        checks_n = 0;
        fail_n   = 0;
        rst_n    = 1'b0;
        bus_if.int_enable_i          = 7'h7F;
        bus_if.configuration_error_i = 1'b0;
        bus_if.overrun_error_i       = 1'b0;
        bus_if.frame_error_i         = 1'b0;
        bus_if.parity_error_i        = 1'b0;
        bus_if.configuration_done_i  = 1'b0;
        bus_if.tx_done_i             = 1'b0;
        bus_if.rx_fifo_empty_i       = 1'b1;
        bus_if.rx_fifo_read_i        = 1'b0;
        bus_if.interrupt_ackn_i      = 1'b0;
        repeat (3) tick();
        check_out("reset", 1'b0, 3'd0, 7'b0000000);
        rst_n = 1'b1;
        repeat (3) tick();

        // single parity event
        bus_if.parity_error_i = 1'b1;
        tick();
        bus_if.parity_error_i = 1'b0;
        check_out("par_latch", 1'b0, 3'd0, 7'b0001000);
        tick();
        check_out("par_rise", 1'b1, 3'd4, 7'b0001000);
        repeat (3) tick();
        check_out("par_hold", 1'b1, 3'd4, 7'b0001000);
        ack();
        check_out("par_ack", 1'b0, 3'd0, 7'b0000000);
        tick();
        tick();
        check_out("par_quiet", 1'b0, 3'd0, 7'b0000000);

        // three simultaneous events presented in priority order; ack during GAP ignored
        bus_if.tx_done_i             = 1'b1;
        bus_if.frame_error_i         = 1'b1;
        bus_if.configuration_error_i = 1'b1;
        tick();
        bus_if.tx_done_i             = 1'b0;
        bus_if.frame_error_i         = 1'b0;
        bus_if.configuration_error_i = 1'b0;
        check_out("multi_latch", 1'b0, 3'd0, 7'b1000101);
        tick();
        check_out("multi_id1", 1'b1, 3'd1, 7'b1000101);
        bus_if.interrupt_ackn_i = 1'b1;
        tick();
        check_out("multi_ack1", 1'b0, 3'd0, 7'b1000100);
        tick();
        bus_if.interrupt_ackn_i = 1'b0;
        check_out("multi_gap1", 1'b0, 3'd0, 7'b1000100);
        tick();
        check_out("multi_id3", 1'b1, 3'd3, 7'b1000100);
        ack();
        check_out("multi_ack3", 1'b0, 3'd0, 7'b1000000);
        tick();
        check("multi_gap3_int", 32'(bus_if.int_o), 32'd0);
        tick();
        check_out("multi_id7", 1'b1, 3'd7, 7'b1000000);
        ack();
        check_out("multi_ack7", 1'b0, 3'd0, 7'b0000000);
        tick();
        tick();

        // disabled source is dropped
        bus_if.int_enable_i = 7'b0111111;
        bus_if.tx_done_i    = 1'b1;
        tick();
        bus_if.tx_done_i = 1'b0;
        seen = bus_if.int_o;
        repeat (4) begin
            tick();
            seen = seen | bus_if.int_o;
        end
        check("dis_pend", 32'(bus_if.pending_o), 32'd0);
        check("dis_never", 32'(seen), 32'd0);
        bus_if.int_enable_i = 7'h7F;

        // no preemption, then set-beats-clear on ack
        bus_if.configuration_done_i = 1'b1;
        tick();
        bus_if.configuration_done_i = 1'b0;
        tick();
        check_out("np_id6", 1'b1, 3'd6, 7'b0100000);
        bus_if.overrun_error_i = 1'b1;
        tick();
        bus_if.overrun_error_i = 1'b0;
        check_out("np_hold6", 1'b1, 3'd6, 7'b0100010);
        ack();
        check_out("np_ack6", 1'b0, 3'd0, 7'b0000010);
        tick();
        check("np_gap_int", 32'(bus_if.int_o), 32'd0);
        tick();
        check_out("np_id2", 1'b1, 3'd2, 7'b0000010);
        bus_if.overrun_error_i  = 1'b1;
        bus_if.interrupt_ackn_i = 1'b1;
        tick();
        bus_if.overrun_error_i  = 1'b0;
        bus_if.interrupt_ackn_i = 1'b0;
        check_out("setwin_ack", 1'b0, 3'd0, 7'b0000010);
        tick();
        tick();
        check_out("setwin_re", 1'b1, 3'd2, 7'b0000010);
        ack();
        check_out("setwin_done", 1'b0, 3'd0, 7'b0000000);
        tick();
        tick();

        // enable drop clears non-presented bits only
        bus_if.frame_error_i  = 1'b1;
        bus_if.parity_error_i = 1'b1;
        tick();
        bus_if.frame_error_i  = 1'b0;
        bus_if.parity_error_i = 1'b0;
        tick();
        check_out("en_id3", 1'b1, 3'd3, 7'b0001100);
        bus_if.int_enable_i = 7'b1110011;
        tick();
        check_out("en_drop", 1'b1, 3'd3, 7'b0000100);
        ack();
        check_out("en_ack", 1'b0, 3'd0, 7'b0000000);
        tick();
        tick();
        check("en_quiet_int", 32'(bus_if.int_o), 32'd0);
        bus_if.int_enable_i = 7'h7F;

        // RX timeout with RX_TIMEOUT_CYC = 8
        bus_if.rx_fifo_empty_i = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus_if.int_o && k < 20);
        check("to_lat", 32'(k), 32'd9);
        check_out("to_id5", 1'b1, 3'd5, 7'b0010000);
        ack();
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | bus_if.int_o;
        end
        check("to_norefire", 32'(seen), 32'd0);
        bus_if.rx_fifo_read_i = 1'b1;
        tick();
        bus_if.rx_fifo_read_i = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus_if.int_o && k < 20);
        check("to_lat2", 32'(k), 32'd9);
        check("to_id5b", 32'(bus_if.int_id_o), 32'd5);
        ack();
        bus_if.rx_fifo_empty_i = 1'b1;
        tick();
        tick();

        // asynchronous reset while presenting with three sources pending
        bus_if.configuration_error_i = 1'b1;
        bus_if.frame_error_i         = 1'b1;
        bus_if.tx_done_i             = 1'b1;
        tick();
        bus_if.configuration_error_i = 1'b0;
        bus_if.frame_error_i         = 1'b0;
        bus_if.tx_done_i             = 1'b0;
        tick();
        check_out("rst_pre", 1'b1, 3'd1, 7'b1000101);
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 3'd0, 7'b0000000);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | bus_if.int_o;
        end
        check("rst_after_int", 32'(seen), 32'd0);
        check("rst_after_pend", 32'(bus_if.pending_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
